// File: rtl/exe_stage_if.sv
// ---------------------------------------------------------------------------
// exe_stage_if.sv
// Bus interfaces around the EXE pipeline stage.
//
//   id_exe_if  : decode/issue -> EXE op bus.
//                master = decode (drives the op, samples exe_allow_in)
//                slave  = EXE    (samples the op, drives exe_allow_in)
//   exe_mem_if : EXE -> MEM result bus.
//                master = EXE    (drives result and pass-through control)
//                slave  = MEM    (samples them, drives mem_allow_in)
// ---------------------------------------------------------------------------
interface id_exe_if;
    logic        id_to_exe_valid;
    logic        exe_allow_in;
    logic [11:0] alu_op;        // one-hot: add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui
    logic [2:0]  div_op;        // {en, signed, mod}
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic        rf_w_en;
    logic [4:0]  rf_w_addr;
    logic [2:0]  rf_w_stage;    // one-hot: b0 EXE, b1 MEM, b2 WB
    logic        rf_w_data_sel;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] inst_pc;

    modport master (
        output id_to_exe_valid, alu_op, div_op, alu_src1, alu_src2,
               rf_w_en, rf_w_addr, rf_w_stage, rf_w_data_sel,
               ram_en, ram_we, ram_wdata, inst_pc,
        input  exe_allow_in
    );
    modport slave (
        input  id_to_exe_valid, alu_op, div_op, alu_src1, alu_src2,
               rf_w_en, rf_w_addr, rf_w_stage, rf_w_data_sel,
               ram_en, ram_we, ram_wdata, inst_pc,
        output exe_allow_in
    );
endinterface

interface exe_mem_if;
    logic        exe_to_mem_valid;
    logic        mem_allow_in;
    logic [31:0] exe_result;    // also the data-RAM address
    logic        rf_w_en;
    logic [4:0]  rf_w_addr;
    logic [2:0]  rf_w_stage;
    logic        rf_w_data_sel;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] inst_pc;

    modport master (
        output exe_to_mem_valid, exe_result, rf_w_en, rf_w_addr, rf_w_stage,
               rf_w_data_sel, ram_en, ram_we, ram_wdata, inst_pc,
        input  mem_allow_in
    );
    modport slave (
        input  exe_to_mem_valid, exe_result, rf_w_en, rf_w_addr, rf_w_stage,
               rf_w_data_sel, ram_en, ram_we, ram_wdata, inst_pc,
        output mem_allow_in
    );
endinterface

// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage.sv
// Fourth pipeline stage: latches one issued op per handshake, evaluates the
// 12-op ALU (or, with EXE_DIV_EN defined, a 32-cycle radix-2 divider), and
// forwards the result plus pass-through control to MEM. Also drives the EXE
// bypass/wake-up signals back to decode.
//
// Build option: define EXE_DIV_EN to include the divider. Without it, div ops
// complete in one cycle with a zero result.
//
// Ports
//   clk           : clock, all state on posedge
//   reset         : synchronous, active-low
//   id_bus        : id_exe_if.slave  - op bus from decode, exe_allow_in back
//   mem_bus       : exe_mem_if.master - result bus to MEM, mem_allow_in back
//   by_w_addr     : bypass destination register
//   by_w_en       : bypass write enable (valid op that writes the RF)
//   by_valid      : stage holds a valid op
//   by_data_valid : by_w_data is final and produced in EXE
//   by_w_data     : bypass data, equal to exe_result
// ---------------------------------------------------------------------------
module exe_stage (
    input  logic        clk,
    input  logic        reset,
    id_exe_if.slave     id_bus,
    exe_mem_if.master   mem_bus,
    output logic [4:0]  by_w_addr,
    output logic        by_w_en,
    output logic        by_valid,
    output logic        by_data_valid,
    output logic [31:0] by_w_data
);
    localparam int DIV_CYCLES = 32;

    logic        valid;
    logic        ready_go;
    logic [11:0] alu_op_q;
    logic        div_en_q;
    logic [31:0] src1_q, src2_q;
    logic        rf_w_en_q, rf_w_data_sel_q, ram_en_q, ram_we_q;
    logic [4:0]  rf_w_addr_q;
    logic [2:0]  rf_w_stage_q;
    logic [31:0] ram_wdata_q, inst_pc_q;
    logic [31:0] alu_result, div_result, exe_result;
`ifdef EXE_DIV_EN
    logic        div_signed_q, div_mod_q;
`endif

    assign id_bus.exe_allow_in = ~valid | (ready_go & mem_bus.mem_allow_in);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the operand/control registers are reset too, not only the
            // valid flag, so the stage's outputs are defined right after reset.
            valid           <= 1'b0;
            alu_op_q        <= '0;
            div_en_q        <= 1'b0;
            src1_q          <= '0;
            src2_q          <= '0;
            rf_w_en_q       <= 1'b0;
            rf_w_addr_q     <= '0;
            rf_w_stage_q    <= '0;
            rf_w_data_sel_q <= 1'b0;
            ram_en_q        <= 1'b0;
            ram_we_q        <= 1'b0;
            ram_wdata_q     <= '0;
            inst_pc_q       <= '0;
`ifdef EXE_DIV_EN
            div_signed_q    <= 1'b0;
            div_mod_q       <= 1'b0;
`endif
        end else if (id_bus.exe_allow_in) begin
            valid <= id_bus.id_to_exe_valid;
            if (id_bus.id_to_exe_valid) begin
                alu_op_q        <= id_bus.alu_op;
                div_en_q        <= id_bus.div_op[2];
                src1_q          <= id_bus.alu_src1;
                src2_q          <= id_bus.alu_src2;
                rf_w_en_q       <= id_bus.rf_w_en;
                rf_w_addr_q     <= id_bus.rf_w_addr;
                rf_w_stage_q    <= id_bus.rf_w_stage;
                rf_w_data_sel_q <= id_bus.rf_w_data_sel;
                ram_en_q        <= id_bus.ram_en;
                ram_we_q        <= id_bus.ram_we;
                ram_wdata_q     <= id_bus.ram_wdata;
                inst_pc_q       <= id_bus.inst_pc;
`ifdef EXE_DIV_EN
                div_signed_q    <= id_bus.div_op[1];
                div_mod_q       <= id_bus.div_op[0];
`endif
            end
        end
    end

    // ALU: one-hot select as an AND-OR tree of all candidate results.
    logic [4:0]  shamt;
    logic [31:0] sra_res;
    assign shamt   = src2_q[4:0];
    assign sra_res = 32'($signed(src1_q) >>> shamt);

    // NOTE: a pure AND-OR expression has a value for every op encoding, so no
    // latch can be inferred even when no op bit is set.
    assign alu_result =
          ({32{alu_op_q[0]}}  & (src1_q + src2_q))
        | ({32{alu_op_q[1]}}  & (src1_q - src2_q))
        | ({32{alu_op_q[2]}}  & {31'd0, $signed(src1_q) < $signed(src2_q)})
        | ({32{alu_op_q[3]}}  & {31'd0, src1_q < src2_q})
        | ({32{alu_op_q[4]}}  & (src1_q & src2_q))
        | ({32{alu_op_q[5]}}  & ~(src1_q | src2_q))
        | ({32{alu_op_q[6]}}  & (src1_q | src2_q))
        | ({32{alu_op_q[7]}}  & (src1_q ^ src2_q))
        | ({32{alu_op_q[8]}}  & (src1_q << shamt))
        | ({32{alu_op_q[9]}}  & (src1_q >> shamt))
        | ({32{alu_op_q[10]}} & sra_res)
        | ({32{alu_op_q[11]}} & src2_q);

`ifdef EXE_DIV_EN
    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

    div_state_t  div_state;
    logic [4:0]  div_cnt;
    logic [31:0] div_quo, div_rem, div_dsr;
    logic        div_neg_q, div_neg_r;
    logic        div_pending;
    logic [31:0] src1_mag, src2_mag;
    logic [32:0] div_trial;

    assign div_pending = valid & div_en_q;
    assign src1_mag    = (div_signed_q & src1_q[31]) ? -src1_q : src1_q;
    assign src2_mag    = (div_signed_q & src2_q[31]) ? -src2_q : src2_q;
    // Restoring step: shift the next dividend bit into the partial remainder
    // and try to subtract; bit 32 set means the subtraction would borrow.
    assign div_trial   = {div_rem, div_quo[31]} - {1'b0, div_dsr};

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_state <= DIV_IDLE;
            div_cnt   <= '0;
            div_quo   <= '0;
            div_rem   <= '0;
            div_dsr   <= '0;
            div_neg_q <= 1'b0;
            div_neg_r <= 1'b0;
        end else begin
            case (div_state)
                DIV_IDLE: if (div_pending) begin
                    div_quo   <= src1_mag;
                    div_rem   <= '0;
                    div_dsr   <= src2_mag;
                    div_cnt   <= '0;
                    // A zero divisor keeps the all-ones quotient unsigned.
                    div_neg_q <= div_signed_q & (src1_q[31] ^ src2_q[31]) & (|src2_q);
                    div_neg_r <= div_signed_q & src1_q[31];
                    div_state <= DIV_RUN;
                end
                DIV_RUN: begin
                    div_cnt <= div_cnt + 5'd1;
                    div_quo <= {div_quo[30:0], ~div_trial[32]};
                    div_rem <= div_trial[32] ? {div_rem[30:0], div_quo[31]} : div_trial[31:0];
                    if (div_cnt == 5'(DIV_CYCLES - 1)) div_state <= DIV_DONE;
                end
                DIV_DONE: if (mem_bus.mem_allow_in) div_state <= DIV_IDLE;
                default:  div_state <= DIV_IDLE;
            endcase
        end
    end

    assign ready_go   = ~div_pending | (div_state == DIV_DONE);
    assign div_result = div_mod_q ? (div_neg_r ? -div_rem : div_rem)
                                  : (div_neg_q ? -div_quo : div_quo);
`else
    // Without the divider the sign/mod bits of div_op have no effect.
    logic div_mode_unused;
    assign div_mode_unused = ^id_bus.div_op[1:0];
    assign ready_go        = 1'b1;
    assign div_result      = '0;
`endif

    assign exe_result = div_en_q ? div_result : alu_result;

    assign mem_bus.exe_to_mem_valid = valid & ready_go;
    assign mem_bus.exe_result       = exe_result;
    assign mem_bus.rf_w_en          = rf_w_en_q;
    assign mem_bus.rf_w_addr        = rf_w_addr_q;
    assign mem_bus.rf_w_stage       = rf_w_stage_q;
    assign mem_bus.rf_w_data_sel    = rf_w_data_sel_q;
    assign mem_bus.ram_en           = ram_en_q;
    assign mem_bus.ram_we           = ram_we_q;
    assign mem_bus.ram_wdata        = ram_wdata_q;
    assign mem_bus.inst_pc          = inst_pc_q;

    assign by_valid      = valid;
    assign by_w_en       = rf_w_en_q & valid;
    assign by_w_addr     = rf_w_addr_q;
    assign by_data_valid = valid & rf_w_stage_q[0] & ready_go;
    assign by_w_data     = exe_result;
endmodule

// File: tb/tb_exe_stage.sv
// ---------------------------------------------------------------------------
// tb_exe_stage.sv
// Self-checking bench for exe_stage. A transaction-level model (a queue of
// accepted ops with their arithmetic results and entry times) predicts the
// handshake, bypass and result outputs on every cycle. Directed ops with
// hand-computed results pin the model; randomized traffic exercises the rest.
// ---------------------------------------------------------------------------
module tb_exe_stage;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    id_exe_if  id_bus ();
    exe_mem_if mem_bus ();
    logic [4:0]  by_w_addr;
    logic        by_w_en, by_valid, by_data_valid;
    logic [31:0] by_w_data;

    exe_stage dut (
        .clk           (clk),
        .reset         (reset),
        .id_bus        (id_bus),
        .mem_bus       (mem_bus),
        .by_w_addr     (by_w_addr),
        .by_w_en       (by_w_en),
        .by_valid      (by_valid),
        .by_data_valid (by_data_valid),
        .by_w_data     (by_w_data)
    );

`ifdef EXE_DIV_EN
    localparam int DIV_LAT = 33;
`else
    localparam int DIV_LAT = 0;
`endif

    typedef struct {
        logic [31:0] result;
        logic        rf_w_en;
        logic [4:0]  rf_w_addr;
        logic [2:0]  rf_w_stage;
        logic        rf_w_data_sel;
        logic        ram_en;
        logic        ram_we;
        logic [31:0] ram_wdata;
        logic [31:0] inst_pc;
        bit          is_div;
        int          enter;
        bit          lit_en;
        logic [31:0] lit;
    } txn_t;

    txn_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          lit_en = 1'b0;
    logic [31:0] lit_val = '0;
    bit          m_ev, m_er;
    txn_t        m_t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    function automatic logic [31:0] model_alu(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 12; i++) begin
            if (op[i]) begin
                case (i)
                    0:  r = a + b;
                    1:  r = a - b;
                    2:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3:  r = (a < b) ? 32'd1 : 32'd0;
                    4:  r = a & b;
                    5:  r = ~(a | b);
                    6:  r = a | b;
                    7:  r = a ^ b;
                    8:  r = a << b[4:0];
                    9:  r = a >> b[4:0];
                    10: r = $signed(a) >>> b[4:0];
                    default: r = b;
                endcase
            end
        end
        return r;
    endfunction

`ifdef EXE_DIV_EN
    function automatic logic [31:0] model_div(input logic sgn, input logic md, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] qv, rv;
        if (b == 32'd0) begin
            qv = 32'hFFFF_FFFF;
            rv = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            qv = 32'h8000_0000;
            rv = 32'd0;
        end else if (sgn) begin
            qv = $signed(a) / $signed(b);
            rv = $signed(a) % $signed(b);
        end else begin
            qv = a / b;
            rv = a % b;
        end
        return md ? rv : qv;
    endfunction
`endif

    // Compare process: mid-cycle, predict and check, then advance the model
    // by the handshakes that the coming posedge will perform.
    always @(negedge clk) begin
        if (mon_en) begin
            m_ev = (q.size() != 0);
            m_er = 1'b1;
            if (m_ev && q[0].is_div && (cyc - q[0].enter) < DIV_LAT) m_er = 1'b0;

            check("by_valid", by_valid, m_ev);
            check("exe_to_mem_valid", mem_bus.exe_to_mem_valid, m_ev & m_er);
            check("exe_allow_in", id_bus.exe_allow_in, !m_ev || (m_er && mem_bus.mem_allow_in));
            if (m_ev) begin
                check("by_w_en", by_w_en, q[0].rf_w_en);
                check("by_w_addr", by_w_addr, q[0].rf_w_addr);
                check("by_data_valid", by_data_valid, q[0].rf_w_stage[0] & m_er);
            end else begin
                check("by_w_en_idle", by_w_en, 0);
                check("by_data_valid_idle", by_data_valid, 0);
            end
            if (m_ev && m_er) begin
                check("exe_result", mem_bus.exe_result, q[0].result);
                check("by_w_data", by_w_data, q[0].result);
                check("rf_w_en", mem_bus.rf_w_en, q[0].rf_w_en);
                check("rf_w_addr", mem_bus.rf_w_addr, q[0].rf_w_addr);
                check("rf_w_stage", mem_bus.rf_w_stage, q[0].rf_w_stage);
                check("rf_w_data_sel", mem_bus.rf_w_data_sel, q[0].rf_w_data_sel);
                check("ram_en", mem_bus.ram_en, q[0].ram_en);
                check("ram_we", mem_bus.ram_we, q[0].ram_we);
                check("ram_wdata", mem_bus.ram_wdata, q[0].ram_wdata);
                check("inst_pc", mem_bus.inst_pc, q[0].inst_pc);
            end

            if (!reset) begin
                q.delete();
            end else begin
                if (m_ev && m_er && mem_bus.mem_allow_in) begin
                    m_t = q.pop_front();
                    if (m_t.lit_en) check("literal_result", mem_bus.exe_result, m_t.lit);
                end
                if (id_bus.id_to_exe_valid && (!m_ev || (m_er && mem_bus.mem_allow_in))) begin
                    m_t.is_div = id_bus.div_op[2];
`ifdef EXE_DIV_EN
                    m_t.result = m_t.is_div
                        ? model_div(id_bus.div_op[1], id_bus.div_op[0], id_bus.alu_src1, id_bus.alu_src2)
                        : model_alu(id_bus.alu_op, id_bus.alu_src1, id_bus.alu_src2);
`else
                    m_t.result = m_t.is_div ? 32'd0 : model_alu(id_bus.alu_op, id_bus.alu_src1, id_bus.alu_src2);
`endif
                    m_t.rf_w_en       = id_bus.rf_w_en;
                    m_t.rf_w_addr     = id_bus.rf_w_addr;
                    m_t.rf_w_stage    = id_bus.rf_w_stage;
                    m_t.rf_w_data_sel = id_bus.rf_w_data_sel;
                    m_t.ram_en        = id_bus.ram_en;
                    m_t.ram_we        = id_bus.ram_we;
                    m_t.ram_wdata     = id_bus.ram_wdata;
                    m_t.inst_pc       = id_bus.inst_pc;
                    m_t.enter         = cyc + 1;
                    m_t.lit_en        = lit_en;
                    m_t.lit           = lit_val;
                    q.push_back(m_t);
                end
            end
        end
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    task automatic randomize_side_fields();
        id_bus.rf_w_en       = 1'($urandom_range(0, 1));
        id_bus.rf_w_addr     = 5'($urandom_range(0, 31));
        id_bus.rf_w_stage    = 3'(1 << $urandom_range(0, 2));
        id_bus.rf_w_data_sel = 1'($urandom_range(0, 1));
        id_bus.ram_en        = 1'($urandom_range(0, 1));
        id_bus.ram_we        = 1'($urandom_range(0, 1));
        id_bus.ram_wdata     = $urandom();
        id_bus.inst_pc       = $urandom() & 32'hFFFF_FFFC;
    endtask

    // Offer one op (called just after a posedge) and hold it until accepted.
    task automatic drive_op(input logic [11:0] aop, input logic [2:0] dop,
                            input logic [31:0] a, input logic [31:0] b,
                            input bit len, input logic [31:0] lit);
        int n;
        randomize_side_fields();
        id_bus.alu_op   = aop;
        id_bus.div_op   = dop;
        id_bus.alu_src1 = a;
        id_bus.alu_src2 = b;
        lit_en  = len;
        lit_val = lit;
        id_bus.id_to_exe_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!id_bus.exe_allow_in && n < 200);
        if (n >= 200) timeout_fail("accept_timeout");
        @(posedge clk);
        #1;
        id_bus.id_to_exe_valid = 1'b0;
        lit_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        id_bus.id_to_exe_valid = 1'b0;
        mem_bus.mem_allow_in   = 1'b1;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            timeout_fail("drain_timeout");
            q.delete();
        end
        #1;
    endtask

`ifdef EXE_DIV_EN
    localparam logic [31:0] L_DIV_Q  = 32'hFFFF_FFFD;
    localparam logic [31:0] L_DIV_R  = 32'hFFFF_FFFF;
    localparam logic [31:0] L_DZ_Q   = 32'hFFFF_FFFF;
    localparam logic [31:0] L_DZ_R   = 32'd100;
    localparam logic [31:0] L_OVF_Q  = 32'h8000_0000;
`else
    localparam logic [31:0] L_DIV_Q  = 32'd0;
    localparam logic [31:0] L_DIV_R  = 32'd0;
    localparam logic [31:0] L_DZ_Q   = 32'd0;
    localparam logic [31:0] L_DZ_R   = 32'd0;
    localparam logic [31:0] L_OVF_Q  = 32'd0;
`endif

    initial begin
        id_bus.id_to_exe_valid = 1'b0;
        id_bus.alu_op          = '0;
        id_bus.div_op          = '0;
        id_bus.alu_src1        = '0;
        id_bus.alu_src2        = '0;
        randomize_side_fields();
        mem_bus.mem_allow_in   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_exe_to_mem_valid", mem_bus.exe_to_mem_valid, 0);
        check("rst_exe_allow_in", id_bus.exe_allow_in, 1);
        check("rst_by_valid", by_valid, 0);
        check("rst_by_data_valid", by_data_valid, 0);
        check("rst_exe_result", mem_bus.exe_result, 0);
        check("rst_inst_pc", mem_bus.inst_pc, 0);
        check("rst_rf_w_en", mem_bus.rf_w_en, 0);
        mon_en = 1'b1;
        reset  = 1'b1;

        // Pin the model against hand-computed values.
        check("model_add", model_alu(12'h001, 32'd5, 32'd7), 32'd12);
        check("model_sra", model_alu(12'h400, 32'h8000_0000, 32'd4), 32'hF800_0000);
        check("model_sltu", model_alu(12'h008, 32'd1, 32'hFFFF_FFFF), 32'd1);
        check("model_slt", model_alu(12'h004, 32'h1234, 32'h1234), 32'd0);
`ifdef EXE_DIV_EN
        check("model_div", model_div(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check("model_mod", model_div(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("model_dz_q", model_div(1'b0, 1'b0, 32'd100, 32'd0), 32'hFFFF_FFFF);
        check("model_dz_r", model_div(1'b0, 1'b1, 32'd100, 32'd0), 32'd100);
`endif

        // Directed ops with literal result expectations.
        drive_op(12'h001, 3'b000, 32'd5, 32'd7, 1'b1, 32'd12);
        drain(50);
        drive_op(12'h400, 3'b000, 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000);
        drive_op(12'h008, 3'b000, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'd1);
        drive_op(12'h004, 3'b000, 32'h1234, 32'h1234, 1'b1, 32'd0);
        drive_op(12'h001, 3'b110, 32'hFFFF_FFF9, 32'd2, 1'b1, L_DIV_Q);
        drive_op(12'h001, 3'b111, 32'hFFFF_FFF9, 32'd2, 1'b1, L_DIV_R);
        drive_op(12'h001, 3'b100, 32'd100, 32'd0, 1'b1, L_DZ_Q);
        drive_op(12'h001, 3'b101, 32'd100, 32'd0, 1'b1, L_DZ_R);
        drive_op(12'h001, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, L_OVF_Q);
        drain(100);

        // Back-pressure: op held for 5 cycles, then exactly one transfer.
        mem_bus.mem_allow_in = 1'b0;
        drive_op(12'h080, 3'b000, 32'hA5A5_0F0F, 32'h0FF0_1234, 1'b1, 32'hAA55_1D3B);
        repeat (5) @(posedge clk);
        #1;
        mem_bus.mem_allow_in = 1'b1;
        drain(20);

        // Reset in the middle of a divide, then a fresh divide.
        drive_op(12'h001, 3'b110, 32'hFFFF_FFF9, 32'd2, 1'b1, L_DIV_Q);
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("rst_mid_by_valid", by_valid, 0);
        check("rst_mid_exe_allow_in", id_bus.exe_allow_in, 1);
        check("rst_mid_exe_to_mem_valid", mem_bus.exe_to_mem_valid, 0);
        drive_op(12'h001, 3'b110, 32'hFFFF_FFF9, 32'd2, 1'b1, L_DIV_Q);
        drain(100);

        // Randomized traffic with random back-pressure.
        repeat (3000) begin
            id_bus.id_to_exe_valid = ($urandom_range(0, 3) != 0);
            id_bus.alu_op          = 12'(1 << $urandom_range(0, 11));
            id_bus.div_op          = {($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3))};
            id_bus.alu_src1        = pick_operand();
            id_bus.alu_src2        = pick_operand();
            randomize_side_fields();
            mem_bus.mem_allow_in   = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
